pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage MIPS pipeline (IF, REG/DECODE, EXE, MEM, WR). It detects load-use hazards against decode-stage consumers, including accelerated BNE and JR resolved in decode. It freezes the whole pipeline while the data memory is not ready, and produces the hold/bubble controls for the pipeline registers. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 16, width of the stall_cnt and freeze_cnt performance counters
- TIMEOUT, 64, number of consecutive freeze cycles after which mem_timeout sets

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk
- id_valid  in  1  decode stage holds a real instruction
- id_rs, id_rt  in  5  decode source registers
- id_xrs, id_xrt  in  1  decode instruction actually reads rs / rt
- ex_regwr, ex_memtoreg  in  1  EXE-stage instruction writes a register / is a load
- ex_wreg  in  5  EXE-stage destination register
- mem_access  in  1  MEM stage is performing LW or SW
- mem_ready  in  1  data memory completes the access this cycle
- clr_cnt  in  1  synchronous clear of both counters
- stall_if  out  1  hold PC and the IF/ID registers
- bubble_id  out  1  load zeros into the ID/EX control fields (RegWr, MemWr, MemToReg)
- freeze  out  1  hold every pipeline register, PC and regfile write enable
- state  out  2  00 RUN, 01 LDSTALL, 10 FREEZE
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- freeze_cnt  out  CNT_W  memory freeze cycles, saturating
- mem_timeout  out  1  sticky: a freeze exceeded TIMEOUT cycles

## Operation
- Load-use hazard (combinational) is true when all of the following hold:
  - id_valid & ex_regwr & ex_memtoreg & (ex_wreg != 0)
  - and either (id_xrs & id_rs == ex_wreg) or (id_xrt & id_rt == ex_wreg)
- Register 0 never causes a hazard.
- ALU producers in EXE and any producer in MEM are covered by forwarding and never stall.
- Mem wait is mem_access & !mem_ready.
- Output priority: mem wait dominates.
  - Mem wait: freeze=1, stall_if=0, bubble_id=0.
  - Else, load-use hazard: stall_if=1, bubble_id=1, freeze=0.
  - Else all three are 0.
- FSM, next state:
  - RUN -> FREEZE on mem wait; else -> LDSTALL on hazard; else stay in RUN.
  - LDSTALL -> FREEZE on mem wait; else -> LDSTALL if the hazard is still true; else -> RUN.
    - After one bubble the load is in MEM, so the hazard clears.
  - FREEZE -> stays in FREEZE while mem wait holds; otherwise -> LDSTALL if hazard, else RUN.
- Counters:
  - stall_cnt increments each cycle bubble_id=1.
  - freeze_cnt increments each cycle freeze=1.
  - Both saturate at all-ones and never wrap.
  - clr_cnt zeroes both and wins over a same-cycle increment.
- Timeout:
  - An internal run counter counts consecutive freeze cycles and clears when freeze=0.
  - When it reaches TIMEOUT, mem_timeout sets and stays set until reset.
  - Freeze continues regardless; mem_timeout does not force progress.
- Reset:
  - While reset=0, stall_if, bubble_id and freeze are forced 0.
  - At the first edge with reset=0: state=RUN, both counters=0, run counter=0, mem_timeout=0.
  - Reset mid-freeze or mid-stall abandons the operation.

## Timing
- stall_if, bubble_id and freeze are Mealy outputs: valid in the same cycle the inputs present. No latency.
- state, counters and mem_timeout update on the rising clk edge following the qualifying cycle.
- A single load-use pair costs exactly 1 bubble cycle.
- A load-use pair overlapped by N freeze cycles costs N+1 lost cycles. The bubble is issued only after the freeze releases.
- mem_timeout is visible one edge after the TIMEOUT-th consecutive freeze cycle.
- Simultaneous clr_cnt and saturation: the counter becomes 0.

## Test plan
- LW $2 in EXE (ex_wreg=2, ex_memtoreg=1), decode ADD reading rs=2:
  - stall_if=bubble_id=1 for exactly 1 cycle; state RUN->LDSTALL->RUN; stall_cnt=1.
- Same pattern with ex_wreg=0, or ex_memtoreg=0 (ALU producer), or id_xrt=0 with rt=2:
  - no stall; state stays 00.
- mem_access=1, mem_ready=0 for 3 cycles while a load-use hazard is present:
  - freeze=1 for 3 cycles with stall_if=0; then 1 bubble cycle; freeze_cnt=3, stall_cnt=1.
- mem_ready held 0 for 64 cycles with TIMEOUT=64:
  - mem_timeout=1 after the 64th cycle and stays 1 after mem_ready returns.
  - It clears only on reset=0.
- CNT_W=4, 20 consecutive bubbles:
  - stall_cnt saturates at 15.
  - clr_cnt on the next hazard cycle gives stall_cnt=0, not 1.
- Assert reset=0 during FREEZE:
  - outputs go 0 immediately; after the edge state=00, counters=0, mem_timeout=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use bubbles against
// decode-stage consumers, whole-pipe freeze on data-memory wait, perf counters, timeout.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_xrs,
  input  logic             id_xrt,
  input  logic             ex_regwr,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             stall_if,
  output logic             bubble_id,
  output logic             freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             mem_timeout
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FREEZE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q, timeout_d;

  logic hazard;
  logic mem_wait;

  // Only a load in EXE can stall; ALU results and anything in MEM are forwarded.
  always_comb begin
    hazard = id_valid & ex_regwr & ex_memtoreg & (ex_wreg != 5'd0) &
             ((id_xrs & (id_rs == ex_wreg)) | (id_xrt & (id_rt == ex_wreg)));
    mem_wait = mem_access & ~mem_ready;
  end

  always_comb begin
    freeze    = 1'b0;
    stall_if  = 1'b0;
    bubble_id = 1'b0;
    if (reset) begin
      freeze    = mem_wait;
      stall_if  = ~mem_wait & hazard;
      bubble_id = ~mem_wait & hazard;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = mem_wait ? FREEZE : (hazard ? LDSTALL : RUN);
      LDSTALL: state_d = mem_wait ? FREEZE : (hazard ? LDSTALL : RUN);
      FREEZE:  state_d = mem_wait ? FREEZE : (hazard ? LDSTALL : RUN);
      default: state_d = RUN;
    endcase
  end

  // Counters saturate at all-ones; a clear beats a same-cycle increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d  = '0;
      freeze_cnt_d = '0;
    end else begin
      if (bubble_id && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (freeze && (freeze_cnt_q != '1))
        freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    run_d = '0;
    if (freeze)
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    timeout_d = timeout_q | (run_d == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
      run_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
      run_q        <= run_d;
      timeout_q    <= timeout_d;
    end
  end

  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign freeze_cnt  = freeze_cnt_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed test-plan steps plus randomized traffic,
// every cycle checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt;
  logic             id_xrs, id_xrt;
  logic             ex_regwr, ex_memtoreg;
  logic [4:0]       ex_wreg;
  logic             mem_access, mem_ready;
  logic             clr_cnt;
  logic             stall_if, bubble_id, freeze;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, freeze_cnt;
  logic             mem_timeout;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  int m_state = 0;
  int m_stall = 0;
  int m_freeze = 0;
  int m_run = 0;
  int m_to = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_xrs(id_xrs), .id_xrt(id_xrt), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .ex_wreg(ex_wreg), .mem_access(mem_access), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .stall_if(stall_if), .bubble_id(bubble_id), .freeze(freeze), .state(state),
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_xrs = 0; id_xrt = 0;
    ex_regwr = 0; ex_memtoreg = 0; ex_wreg = 0;
    mem_access = 0; mem_ready = 1; clr_cnt = 0;
  endtask

  // LW $w in EXE, decode instruction reading rs/rt as given
  task automatic load_use(input int w, input int rs, input int rt, input bit xrs, input bit xrt);
    id_valid = 1; id_rs = 5'(rs); id_rt = 5'(rt); id_xrs = xrs; id_xrt = xrt;
    ex_regwr = 1; ex_memtoreg = 1; ex_wreg = 5'(w);
  endtask

  // One cycle: inputs already applied (after negedge). Checks Mealy outputs,
  // advances the model across the edge, then checks registered outputs.
  task automatic cyc();
    bit haz, mw;
    int e_frz, e_stl;
    haz = id_valid && ex_regwr && ex_memtoreg && (ex_wreg != 0) &&
          ((id_xrs && id_rs == ex_wreg) || (id_xrt && id_rt == ex_wreg));
    mw = mem_access && !mem_ready;
    e_frz = (reset && mw) ? 1 : 0;
    e_stl = (reset && !mw && haz) ? 1 : 0;
    #1;
    chk("freeze", int'(freeze), e_frz);
    chk("stall_if", int'(stall_if), e_stl);
    chk("bubble_id", int'(bubble_id), e_stl);
    @(posedge clk);
    if (!reset) begin
      m_state = 0; m_stall = 0; m_freeze = 0; m_run = 0; m_to = 0;
    end else begin
      m_state = mw ? 2 : (haz ? 1 : 0);
      if (clr_cnt) begin
        m_stall = 0; m_freeze = 0;
      end else begin
        if (e_stl == 1 && m_stall < CMAX) m_stall++;
        if (e_frz == 1 && m_freeze < CMAX) m_freeze++;
      end
      m_run = (e_frz == 1) ? m_run + 1 : 0;
      if (m_run >= TIMEOUT) m_to = 1;
    end
    #1;
    chk("state", int'(state), m_state);
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("freeze_cnt", int'(freeze_cnt), m_freeze);
    chk("mem_timeout", int'(mem_timeout), m_to);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 0;
    @(negedge clk);
    cyc();
    cyc();
    chk("reset_state", int'(state), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    reset = 1;
    cyc();

    // single load-use pair: one bubble, RUN->LDSTALL->RUN
    load_use(2, 2, 7, 1, 1);
    cyc();
    chk("lu_state", int'(state), 1);
    idle(); id_valid = 1; id_rs = 2; id_xrs = 1;
    cyc();
    chk("lu_back_run", int'(state), 0);
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    // no-stall variants
    load_use(0, 0, 0, 1, 1); cyc(); chk("r0_state", int'(state), 0);
    load_use(2, 2, 2, 1, 1); ex_memtoreg = 0; cyc(); chk("alu_state", int'(state), 0);
    load_use(2, 5, 2, 1, 0); cyc(); chk("xrt0_state", int'(state), 0);
    load_use(3, 9, 3, 0, 1); cyc(); chk("rt_hazard", int'(state), 1);
    idle(); cyc();

    // 3 freeze cycles over a pending hazard, then one bubble
    clr_cnt = 1; cyc(); clr_cnt = 0;
    load_use(4, 4, 0, 1, 0); mem_access = 1; mem_ready = 0;
    repeat (3) cyc();
    chk("frz_state", int'(state), 2);
    mem_ready = 1;
    cyc();
    idle(); cyc();
    chk("frz_freeze_cnt", int'(freeze_cnt), 3);
    chk("frz_stall_cnt", int'(stall_cnt), 1);

    // timeout after 64 consecutive freeze cycles, sticky until reset
    mem_access = 1; mem_ready = 0;
    repeat (TIMEOUT - 1) cyc();
    chk("to_not_yet", int'(mem_timeout), 0);
    cyc();
    chk("to_set", int'(mem_timeout), 1);
    idle(); repeat (3) cyc();
    chk("to_sticky", int'(mem_timeout), 1);
    reset = 0; cyc(); reset = 1;
    chk("to_cleared", int'(mem_timeout), 0);

    // 20 bubbles saturate a 4-bit counter; clr wins over increment
    load_use(6, 6, 0, 1, 0);
    repeat (20) cyc();
    chk("sat_stall_cnt", int'(stall_cnt), CMAX);
    clr_cnt = 1; cyc(); clr_cnt = 0;
    chk("clr_wins", int'(stall_cnt), 0);
    idle(); cyc();

    // reset asserted during freeze
    mem_access = 1; mem_ready = 0;
    repeat (4) cyc();
    reset = 0;
    cyc();
    chk("rst_frz_state", int'(state), 0);
    chk("rst_frz_cnt", int'(freeze_cnt), 0);
    reset = 1; idle(); cyc();

    // randomized traffic on a small register subset
    for (int i = 0; i < 400; i++) begin
      id_valid    = ($urandom_range(0, 9) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_xrs      = 1'($urandom);
      id_xrt      = 1'($urandom);
      ex_regwr    = ($urandom_range(0, 3) != 0);
      ex_memtoreg = 1'($urandom);
      ex_wreg     = 5'($urandom_range(0, 3));
      mem_access  = 1'($urandom);
      mem_ready   = ($urandom_range(0, 2) != 0);
      clr_cnt     = ($urandom_range(0, 29) == 0);
      reset       = ($urandom_range(0, 59) != 0);
      cyc();
    end
    reset = 1; idle(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
